mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one unified, variable-latency memory port between the hart's instruction-fetch requester and its data (load/store) requester.
- Replaces the combinational imem/dmem model with valid/ready request and response handshakes.
- Allows exactly one outstanding transaction.
- Sits between the hart's fetch/memory stages and the memory model/bus.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while fetch is waiting before fetch is forced to win (1..15)

Ports:
i_clk  input  1  global clock, rising edge
i_rst_n  input  1  reset; one clock; reset is asynchronous and active-low
i_if_req_valid  input  1  fetch request valid
o_if_req_ready  output  1  fetch request accepted this cycle
i_if_addr  input  32  fetch address
o_if_rsp_valid  output  1  fetch response valid, one-cycle pulse
o_if_rdata  output  32  fetched instruction word
i_dm_req_valid  input  1  data request valid
o_dm_req_ready  output  1  data request accepted this cycle
i_dm_addr  input  32  data address
i_dm_wen  input  1  1 = store, 0 = load
i_dm_wdata  input  32  store data, already lane-shifted
i_dm_mask  input  4  byte-lane mask
o_dm_rsp_valid  output  1  data response valid, one-cycle pulse; also the store ack
o_dm_rdata  output  32  load data; don't care for stores
o_mem_req_valid  output  1  request to memory
i_mem_req_ready  input  1  memory accepts request
o_mem_addr  output  32  word-aligned address
o_mem_wen  output  1  write enable
o_mem_wdata  output  32  write data
o_mem_mask  output  4  byte mask
i_mem_rsp_valid  input  1  memory response (reads and writes)
i_mem_rdata  input  32  memory read data
o_busy  output  1  state != IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (async assert, sync deassert by the surrounding reset logic):
  - state = IDLE; starvation counter = 0.
  - All valid/ready outputs = 0.
  - All data/address outputs = 0.
  - Latched grant = fetch.
- Grant in IDLE is combinational:
  - If only one requester is valid, it wins.
  - If both are valid, data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- Ready signals are combinational:
  - o_x_req_ready = (state == IDLE) & i_x_req_valid & granted(x).
  - Both readys are never 1 in the same cycle.
- Acceptance (valid & ready):
  - Latch addr with bits [1:0] forced to 0; latch wen, wdata, mask, and grant. Fetch latches wen = 0, mask = 4'b1111, wdata = 0.
  - Go to ISSUE.
- ISSUE:
  - o_mem_req_valid = 1 with latched fields held stable.
  - On i_mem_req_ready, go to WAIT.
  - No timeout.
- WAIT:
  - On i_mem_rsp_valid, capture i_mem_rdata and go to RESP.
  - i_mem_rsp_valid in any other state is ignored.
- RESP:
  - Assert o_if_rsp_valid or o_dm_rsp_valid (per latched grant) for exactly one cycle, with rdata from the capture register.
  - Go to IDLE.
  - rdata outputs hold their value until the next capture.
- Minimum occupancy: accept (cycle 0) -> ISSUE (1) -> WAIT (2, with same-cycle ready) -> RESP (3) -> IDLE (4).
  - When ready and rsp both arrive one cycle after issue, a new accept happens at cycle 4.
- Starvation counter:
  - Increments on each data acceptance while i_if_req_valid = 1, saturating at STARVE_LIMIT.
  - Clears to 0 on fetch acceptance, or in any IDLE cycle with i_if_req_valid = 0.
- Requester rules:
  - Requesters hold valid and fields stable until ready; the block does not re-sample unaccepted requests.
  - Dropping valid before ready is legal and withdraws the request.
- Mask/alignment:
  - Mask is forwarded unchanged; no alignment checks (traps are the hart's responsibility).
  - A mask of 0 is forwarded as-is and still completes with a response.
- Reset mid-transaction returns the block to IDLE immediately.
  - The in-flight request is abandoned and no response pulse is generated.
  - The memory shares i_rst_n and discards its state too.

Test Plan:
- Single fetch: if_valid, addr 0x00000106, mem ready same cycle, rsp 1 cycle later with 0x00100093. Required: mem_addr = 0x00000104, mask = 1111, wen = 0; o_if_rsp_valid one-cycle pulse at cycle 3 with rdata 0x00100093.
- Contention: both valid in the same cycle, dm = store 0x2003, mask 1000, wdata 0xAB000000. Required: dm granted first, mem_addr 0x2000, wen = 1; o_dm_rsp_valid pulse; fetch granted next in IDLE.
- Starvation: if_valid held high, dm_valid held high continuously, STARVE_LIMIT = 4. Required: exactly 4 data grants, then a fetch grant, then the counter clears.
- Backpressure: i_mem_req_ready low for 5 cycles in ISSUE. Required: o_mem_req_valid stays 1 with unchanged fields; both req_readys stay 0; o_busy = 1 throughout.
- Stray response: i_mem_rsp_valid pulsed in IDLE and in ISSUE. Required: no rsp_valid outputs and no state change.
- Reset mid-WAIT: assert i_rst_n = 0 asynchronously. Required: all outputs 0 within the same cycle; no response pulse after release; the next request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates one unified, single-outstanding memory port between the fetch and data
// requesters. Data wins ties unless fetch has been starved for STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_if_req_valid,
  output logic        o_if_req_ready,
  input  logic [31:0] i_if_addr,
  output logic        o_if_rsp_valid,
  output logic [31:0] o_if_rdata,
  input  logic        i_dm_req_valid,
  output logic        o_dm_req_ready,
  input  logic [31:0] i_dm_addr,
  input  logic        i_dm_wen,
  input  logic [31:0] i_dm_wdata,
  input  logic [3:0]  i_dm_mask,
  output logic        o_dm_rsp_valid,
  output logic [31:0] o_dm_rdata,
  output logic        o_mem_req_valid,
  input  logic        i_mem_req_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state;
  logic        grant_dm_q;
  logic [3:0]  starve_cnt;
  logic [31:0] rdata_q;
  logic        mem_req_valid_q;
  logic [31:0] mem_addr_q;
  logic        mem_wen_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_mask_q;
  logic        if_rsp_q;
  logic        dm_rsp_q;
  logic        grant_dm_c;

  // Handshake rule for every channel: a transfer happens in the cycle where valid and
  // ready are both high; requesters keep valid and fields stable until then, and may drop
  // valid to withdraw. Readys are only offered in IDLE and are held low during reset.
  always_comb begin
    grant_dm_c = i_dm_req_valid & (~i_if_req_valid | (starve_cnt != LIMIT));
  end

  assign o_if_req_ready = i_rst_n & (state == IDLE) & i_if_req_valid & ~grant_dm_c;
  assign o_dm_req_ready = i_rst_n & (state == IDLE) & i_dm_req_valid & grant_dm_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      grant_dm_q      <= 1'b0;
      starve_cnt      <= '0;
      rdata_q         <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= '0;
      mem_mask_q      <= '0;
      if_rsp_q        <= 1'b0;
      dm_rsp_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (o_dm_req_ready) begin
            grant_dm_q      <= 1'b1;
            mem_addr_q      <= i_dm_addr & ~32'h3;
            mem_wen_q       <= i_dm_wen;
            mem_wdata_q     <= i_dm_wdata;
            mem_mask_q      <= i_dm_mask;
            mem_req_valid_q <= 1'b1;
            state           <= ISSUE;
            // Only data wins taken at fetch's expense count toward starvation.
            if (!i_if_req_valid)        starve_cnt <= '0;
            else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
          end else if (o_if_req_ready) begin
            grant_dm_q      <= 1'b0;
            mem_addr_q      <= i_if_addr & ~32'h3;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_mask_q      <= 4'b1111;
            mem_req_valid_q <= 1'b1;
            starve_cnt      <= '0;
            state           <= ISSUE;
          end else if (!i_if_req_valid) begin
            starve_cnt <= '0;
          end
        end
        ISSUE: begin
          if (i_mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= WAIT;
          end
        end
        WAIT: begin
          if (i_mem_rsp_valid) begin
            rdata_q  <= i_mem_rdata;
            if_rsp_q <= ~grant_dm_q;
            dm_rsp_q <= grant_dm_q;
            state    <= RESP;
          end
        end
        RESP: begin
          if_rsp_q <= 1'b0;
          dm_rsp_q <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_mem_req_valid = mem_req_valid_q;
  assign o_mem_addr      = mem_addr_q;
  assign o_mem_wen       = mem_wen_q;
  assign o_mem_wdata     = mem_wdata_q;
  assign o_mem_mask      = mem_mask_q;
  assign o_if_rsp_valid  = if_rsp_q;
  assign o_dm_rsp_valid  = dm_rsp_q;
  assign o_if_rdata      = rdata_q;
  assign o_dm_rdata      = rdata_q;
  assign o_busy          = (state != IDLE);
  assign o_dbg_state     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus hand-written
// sequences for contention, starvation, backpressure, stray responses and reset.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rdata;
  logic        dm_req_valid;
  logic        dm_req_ready;
  logic [31:0] dm_addr;
  logic        dm_wen;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_mask;
  logic        dm_rsp_valid;
  logic [31:0] dm_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [1:0]  dbg_state;

  int tests;
  int fails;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_if_req_valid(if_req_valid), .o_if_req_ready(if_req_ready), .i_if_addr(if_addr),
    .o_if_rsp_valid(if_rsp_valid), .o_if_rdata(if_rdata),
    .i_dm_req_valid(dm_req_valid), .o_dm_req_ready(dm_req_ready), .i_dm_addr(dm_addr),
    .i_dm_wen(dm_wen), .i_dm_wdata(dm_wdata), .i_dm_mask(dm_mask),
    .o_dm_rsp_valid(dm_rsp_valid), .o_dm_rdata(dm_rdata),
    .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready), .o_mem_addr(mem_addr),
    .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
    .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rdata(mem_rdata),
    .o_busy(busy), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        is_dm;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rd;
    int          rdel;
    int          sdel;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_mask;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: act=0x%08h exp=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // driver tasks; all start and end 1 time unit after a rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Call in the first ISSUE cycle; returns in the RESP cycle.
  task automatic mem_finish(input logic [31:0] rd);
    mem_req_ready = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = rd;
    next_cycle();
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0BAD_0BAD;
  endtask

  task automatic run_txn(input vec_t v);
    if_req_valid = ~v.is_dm;
    dm_req_valid = v.is_dm;
    if_addr      = v.addr;
    dm_addr      = v.addr;
    dm_wen       = v.wen;
    dm_wdata     = v.wdata;
    dm_mask      = v.mask;
    @(negedge clk);
    check("txn_if_ready", {31'd0, if_req_ready}, {31'd0, ~v.is_dm});
    check("txn_dm_ready", {31'd0, dm_req_ready}, {31'd0, v.is_dm});
    next_cycle();
    if_req_valid = 1'b0;
    dm_req_valid = 1'b0;
    for (int k = 0; k < v.rdel; k++) begin
      @(negedge clk);
      check("txn_stall_valid", {31'd0, mem_req_valid}, 32'd1);
      check("txn_stall_addr", mem_addr, v.exp_addr);
      next_cycle();
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    check("txn_mem_valid", {31'd0, mem_req_valid}, 32'd1);
    check("txn_mem_addr", mem_addr, v.exp_addr);
    check("txn_mem_wen", {31'd0, mem_wen}, {31'd0, v.exp_wen});
    check("txn_mem_wdata", mem_wdata, v.exp_wdata);
    check("txn_mem_mask", {28'd0, mem_mask}, {28'd0, v.exp_mask});
    check("txn_busy", {31'd0, busy}, 32'd1);
    next_cycle();
    mem_req_ready = 1'b0;
    for (int k = 0; k < v.sdel; k++) begin
      @(negedge clk);
      check("txn_wait_state", {30'd0, dbg_state}, 32'd2);
      check("txn_wait_novalid", {31'd0, mem_req_valid}, 32'd0);
      next_cycle();
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = v.rd;
    next_cycle();
    mem_rsp_valid = 1'b0;
    mem_rdata     = 32'h0BAD_0BAD;
    @(negedge clk);
    check("txn_if_rsp", {31'd0, if_rsp_valid}, {31'd0, ~v.is_dm});
    check("txn_dm_rsp", {31'd0, dm_rsp_valid}, {31'd0, v.is_dm});
    if (!v.is_dm) check("txn_if_rdata", if_rdata, v.rd);
    else if (!v.wen) check("txn_dm_rdata", dm_rdata, v.rd);
    next_cycle();
    @(negedge clk);
    check("txn_pulse_end", {30'd0, if_rsp_valid, dm_rsp_valid}, 32'd0);
    check("txn_idle", {31'd0, busy}, 32'd0);
    if (!v.is_dm) check("txn_rdata_hold", if_rdata, v.rd);
    next_cycle();
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp_grant;
  logic [31:0] held_addr;

  initial begin
    tests = 0;
    fails = 0;
    // fetch rows drive junk on the data-side fields to show they are not forwarded
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0106, 32'hFFFF_FFFF, 4'b0101, 32'h0010_0093, 0, 0,
                32'h0000_0104, 1'b0, 32'h0, 4'b1111};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_1002, 32'h0,         4'b0011, 32'hDEAD_BEEF, 2, 1,
                32'h0000_1000, 1'b0, 32'h0, 4'b0011};
    vecs[2] = '{1'b1, 1'b1, 32'h7FFF_FFFF, 32'h1234_0000, 4'b1100, 32'h55AA_55AA, 0, 2,
                32'h7FFF_FFFC, 1'b1, 32'h1234_0000, 4'b1100};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'b0000, 32'h0,         1, 0,
                32'h0000_0040, 1'b1, 32'hCAFE_F00D, 4'b0000};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1111_1111, 4'b0001, 32'hA5A5_0F0F, 1, 3,
                32'hFFFF_FFFC, 1'b0, 32'h0, 4'b1111};

    rst_n = 1'b0;
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wen = 1'b0; dm_wdata = '0; dm_mask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
    #12;
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_valids", {27'd0, mem_req_valid, if_rsp_valid, dm_rsp_valid, if_req_ready,
                         dm_req_ready}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_rdata", if_rdata | dm_rdata | mem_wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // contention: data wins first, then the waiting fetch
    if_req_valid = 1'b1; if_addr = 32'h0000_0200;
    dm_req_valid = 1'b1; dm_addr = 32'h0000_2003; dm_wen = 1'b1;
    dm_wdata = 32'hAB00_0000; dm_mask = 4'b1000;
    @(negedge clk);
    check("cont_dm_ready", {31'd0, dm_req_ready}, 32'd1);
    check("cont_if_ready", {31'd0, if_req_ready}, 32'd0);
    next_cycle();
    dm_req_valid = 1'b0;
    @(negedge clk);
    check("cont_addr", mem_addr, 32'h0000_2000);
    check("cont_wen", {31'd0, mem_wen}, 32'd1);
    check("cont_wdata", mem_wdata, 32'hAB00_0000);
    check("cont_mask", {28'd0, mem_mask}, 32'h8);
    mem_finish(32'h0);
    @(negedge clk);
    check("cont_dm_rsp", {30'd0, if_rsp_valid, dm_rsp_valid}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("cont_if_ready2", {30'd0, if_req_ready, dm_req_ready}, 32'd2);
    next_cycle();
    if_req_valid = 1'b0;
    @(negedge clk);
    check("cont_if_addr", mem_addr, 32'h0000_0200);
    mem_finish(32'h0000_0013);
    @(negedge clk);
    check("cont_if_rsp", {30'd0, if_rsp_valid, dm_rsp_valid}, 32'd2);
    check("cont_if_rdata", if_rdata, 32'h0000_0013);
    next_cycle();

    // starvation: both held high; 1 = data grant, 0 = fetch grant
    exp_q = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd1};
    if_req_valid = 1'b1; if_addr = 32'h0000_0300;
    dm_req_valid = 1'b1; dm_addr = 32'h0000_4000; dm_wen = 1'b0; dm_mask = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      exp_grant = exp_q.pop_front();
      check("starve_dm_ready", {31'd0, dm_req_ready}, exp_grant);
      check("starve_if_ready", {31'd0, if_req_ready}, {31'd0, ~exp_grant[0]});
      next_cycle();
      mem_finish(32'h0);
      next_cycle();
    end
    if_req_valid = 1'b0; dm_req_valid = 1'b0;

    // backpressure in ISSUE with both requesters knocking
    dm_req_valid = 1'b1; dm_addr = 32'h0000_3006; dm_wen = 1'b0; dm_mask = 4'b0011;
    next_cycle();
    if_req_valid = 1'b1;
    held_addr = 32'h0000_3004;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, mem_req_valid}, 32'd1);
      check("bp_addr", mem_addr, held_addr);
      check("bp_mask_wen", {27'd0, mem_mask, mem_wen}, {27'd0, 4'b0011, 1'b0});
      check("bp_readys", {30'd0, if_req_ready, dm_req_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      next_cycle();
    end
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    mem_finish(32'h7777_8888);
    @(negedge clk);
    check("bp_dm_rsp", {30'd0, if_rsp_valid, dm_rsp_valid}, 32'd1);
    check("bp_rdata", dm_rdata, 32'h7777_8888);
    next_cycle();

    // stray responses in IDLE and ISSUE
    mem_rsp_valid = 1'b1; mem_rdata = 32'hEEEE_EEEE;
    next_cycle();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("stray_idle_rsp", {30'd0, if_rsp_valid, dm_rsp_valid}, 32'd0);
    check("stray_idle_state", {30'd0, dbg_state}, 32'd0);
    if_req_valid = 1'b1; if_addr = 32'h0000_0500;
    next_cycle();
    if_req_valid = 1'b0;
    mem_rsp_valid = 1'b1;
    next_cycle();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("stray_issue_state", {30'd0, dbg_state}, 32'd1);
    check("stray_issue_rsp", {30'd0, if_rsp_valid, dm_rsp_valid}, 32'd0);
    mem_finish(32'h0000_0517);
    @(negedge clk);
    check("stray_real_rsp", {30'd0, if_rsp_valid, dm_rsp_valid}, 32'd2);
    check("stray_real_rdata", if_rdata, 32'h0000_0517);
    next_cycle();

    // asynchronous reset while in WAIT
    if_req_valid = 1'b1; if_addr = 32'h0000_0600;
    next_cycle();
    if_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    next_cycle();
    mem_req_ready = 1'b0;
    dm_req_valid = 1'b1; dm_addr = 32'h0000_0700;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_state", {30'd0, dbg_state}, 32'd0);
    check("rst_mid_valids", {27'd0, mem_req_valid, if_rsp_valid, dm_rsp_valid, if_req_ready,
                             dm_req_ready}, 32'd0);
    check("rst_mid_data", mem_addr | mem_wdata | if_rdata, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    dm_req_valid = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    next_cycle();
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_pulse", {29'd0, if_rsp_valid, dm_rsp_valid, busy}, 32'd0);
      next_cycle();
    end
    run_txn(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
